// File: rtl/dma_request_scheduler_pkg.sv
// ============================================================================
// dma_pkg : shared types and helpers for the DMA request scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package dma_pkg;

  localparam int ADDR_W = 32;
  localparam int SIZE_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_REJECT = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ISSUE  = ST_ISSUE,
    S_WAIT   = ST_WAIT,
    S_DONE   = ST_DONE,
    S_REJECT = ST_REJECT,
    S_FAULT  = ST_FAULT
  } state_e;

  // The splitter aborts on a negative (bit31) size, so those never get issued.
  function automatic logic size_valid(input logic [SIZE_W-1:0] size);
    return (size != '0) && !size[SIZE_W-1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_request_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick starting after last_grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        last_grant,
  output logic              grant_valid,
  output logic [2:0]        grant_idx
);

  logic [2:0]        start;
  logic [NUM_CH-1:0] rot;
  logic [2:0]        off;
  logic [3:0]        sum;

  always_comb begin
    start = (last_grant >= 3'(NUM_CH - 1)) ? 3'd0 : last_grant + 3'd1;

    // Rotate so the search origin sits at bit 0, pick lowest, rotate back.
    rot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rot[i] = req[(i + int'(start)) % NUM_CH];
    end

    grant_valid = |rot;
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end

    sum = {1'b0, off} + {1'b0, start};
    grant_idx = (sum >= 4'(NUM_CH)) ? 3'(sum - 4'(NUM_CH)) : sum[2:0];
  end

endmodule

`default_nettype wire

// File: rtl/dma_request_scheduler.sv
// ============================================================================
// dma_request_scheduler : round-robin front end sharing one transmission_spliter
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_request_scheduler
  import dma_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr_host,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr_device,
  input  logic [SIZE_W*NUM_CH-1:0] ch_size,
  input  logic [NUM_CH-1:0]        ch_dir_write,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [ADDR_W-1:0]        conf_start_address_host,
  output logic [ADDR_W-1:0]        conf_start_address_device,
  output logic [SIZE_W-1:0]        conf_size,
  output logic                     conf_dir_write,
  output logic                     conf_valid,
  input  logic                     conf_transaction_done,
  output logic                     busy,
  output logic [2:0]               active_ch,
  output logic                     fault
);

  localparam logic              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]       TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ONE     = NUM_CH'(1);

  state_e              state_q;
  logic [2:0]          last_grant_q;
  logic [2:0]          active_ch_q;
  logic [ADDR_W-1:0]   host_q;
  logic [ADDR_W-1:0]   dev_q;
  logic [SIZE_W-1:0]   size_q;
  logic                dir_q;
  logic                conf_valid_q;
  logic [NUM_CH-1:0]   ack_q;
  logic [NUM_CH-1:0]   err_q;
  logic                busy_q;
  logic                fault_q;
  logic [31:0]         cnt_q;

  logic                grant_valid;
  logic [2:0]          grant_idx;
  logic [ADDR_W-1:0]   sel_host;
  logic [ADDR_W-1:0]   sel_dev;
  logic [SIZE_W-1:0]   sel_size;
  logic                sel_dir;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req         (ch_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    sel_host = '0;
    sel_dev  = '0;
    sel_size = '0;
    sel_dir  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == 3'(k)) begin
        sel_host = ch_addr_host[ADDR_W*k +: ADDR_W];
        sel_dev  = ch_addr_device[ADDR_W*k +: ADDR_W];
        sel_size = ch_size[SIZE_W*k +: SIZE_W];
        sel_dir  = ch_dir_write[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 3'(NUM_CH - 1);
      active_ch_q  <= '0;
      host_q       <= '0;
      dev_q        <= '0;
      size_q       <= '0;
      dir_q        <= 1'b0;
      conf_valid_q <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      conf_valid_q <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            last_grant_q <= grant_idx;
            active_ch_q  <= grant_idx;
            host_q       <= sel_host;
            dev_q        <= sel_dev;
            size_q       <= sel_size;
            dir_q        <= sel_dir;
            busy_q       <= 1'b1;
            if (size_valid(sel_size)) begin
              state_q      <= S_ISSUE;
              conf_valid_q <= 1'b1;
            end else begin
              state_q <= S_REJECT;
              err_q   <= ONE << grant_idx;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
          if (conf_transaction_done) begin
            state_q <= S_DONE;
            ack_q   <= ONE << active_ch_q;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            err_q   <= ONE << active_ch_q;
          end
        end
        S_DONE, S_REJECT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_FAULT: begin
          fault_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ch_ack                    = ack_q;
  assign ch_err                    = err_q;
  assign conf_start_address_host   = host_q;
  assign conf_start_address_device = dev_q;
  assign conf_size                 = size_q;
  assign conf_dir_write            = dir_q;
  assign conf_valid                = conf_valid_q;
  assign busy                      = busy_q;
  assign active_ch                 = active_ch_q;
  assign fault                     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_request_scheduler.sv
// ============================================================================
// tb_dma_request_scheduler : directed checks of grant, reject, timeout, reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_request_scheduler;

  logic          clk = 1'b0;
  logic          rst, rst_b;
  logic [3:0]    req, req_b;
  logic [127:0]  a_host, a_dev, a_size;
  logic [3:0]    a_dir;
  logic          done;

  logic [3:0]    ack, err, ack_b, err_b;
  logic [31:0]   c_host, c_dev, c_size, c_host_b, c_dev_b, c_size_b;
  logic          c_dir, c_valid, bsy, flt;
  logic          c_dir_b, c_valid_b, bsy_b, flt_b;
  logic [2:0]    act, act_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dma_request_scheduler #(.NUM_CH(4), .TIMEOUT_CYCLES(65535)) u_dut (
    .i_clk(clk), .i_rst(rst), .ch_req(req),
    .ch_addr_host(a_host), .ch_addr_device(a_dev), .ch_size(a_size), .ch_dir_write(a_dir),
    .ch_ack(ack), .ch_err(err),
    .conf_start_address_host(c_host), .conf_start_address_device(c_dev),
    .conf_size(c_size), .conf_dir_write(c_dir), .conf_valid(c_valid),
    .conf_transaction_done(done), .busy(bsy), .active_ch(act), .fault(flt)
  );

  dma_request_scheduler #(.NUM_CH(4), .TIMEOUT_CYCLES(16)) u_dut_to (
    .i_clk(clk), .i_rst(rst_b), .ch_req(req_b),
    .ch_addr_host(a_host), .ch_addr_device(a_dev), .ch_size(a_size), .ch_dir_write(a_dir),
    .ch_ack(ack_b), .ch_err(err_b),
    .conf_start_address_host(c_host_b), .conf_start_address_device(c_dev_b),
    .conf_size(c_size_b), .conf_dir_write(c_dir_b), .conf_valid(c_valid_b),
    .conf_transaction_done(1'b0), .busy(bsy_b), .active_ch(act_b), .fault(flt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] h, input logic [31:0] d,
                        input logic [31:0] s, input logic w);
    a_host[32*k +: 32] = h;
    a_dev[32*k +: 32]  = d;
    a_size[32*k +: 32] = s;
    a_dir[k]           = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] exp_seq [6];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};

    rst = 1'b1; rst_b = 1'b1; req = '0; req_b = '0; done = 1'b0;
    a_host = '0; a_dev = '0; a_size = '0; a_dir = '0;
    tick(); tick();

    // Reset state
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_valid", 32'(c_valid), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_fault", 32'(flt), 0);
    chk("rst_size", c_size, 0);
    chk("rst_active", 32'(act), 0);
    rst = 1'b0; rst_b = 1'b0;
    tick();

    // Single request on channel 1
    set_ch(1, 32'h1000, 32'h2000, 32'd512, 1'b0);
    req = 4'b0010;
    tick();
    chk("single_valid", 32'(c_valid), 1);
    chk("single_host", c_host, 32'h1000);
    chk("single_dev", c_dev, 32'h2000);
    chk("single_size", c_size, 32'd512);
    chk("single_dir", 32'(c_dir), 0);
    chk("single_active", 32'(act), 1);
    tick();
    chk("single_valid_1cyc", 32'(c_valid), 0);
    chk("single_busy_wait", 32'(bsy), 1);
    for (int i = 0; i < 19; i++) tick();
    chk("single_no_early_ack", 32'(ack), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("single_ack", 32'(ack), 32'h2);
    chk("single_busy_done", 32'(bsy), 1);
    req = 4'b0000;
    tick();
    chk("single_ack_1cyc", 32'(ack), 0);
    chk("single_busy_idle", 32'(bsy), 0);

    // Contention: four requesters, restart from reset priority
    rst = 1'b1; tick(); rst = 1'b0;
    set_ch(0, 32'hA000, 32'hB000, 32'h40, 1'b0);
    set_ch(1, 32'hA100, 32'hB100, 32'h41, 1'b1);
    set_ch(2, 32'hA200, 32'hB200, 32'h42, 1'b0);
    set_ch(3, 32'hA300, 32'hB300, 32'h43, 1'b1);
    for (int i = 0; i < 6; i++) begin
      req = 4'hF;
      tick();
      chk($sformatf("rr%0d_valid", i), 32'(c_valid), 1);
      chk($sformatf("rr%0d_active", i), 32'(act), 32'(exp_seq[i]));
      chk($sformatf("rr%0d_host", i), c_host, 32'hA000 + 32'h100 * 32'(exp_seq[i]));
      chk($sformatf("rr%0d_dir", i), 32'(c_dir), 32'(exp_seq[i][0]));
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk($sformatf("rr%0d_ack", i), 32'(ack), 32'(4'b0001 << exp_seq[i]));
      req[exp_seq[i]] = 1'b0;
      tick();
    end
    req = 4'b0000;
    tick();
    chk("rr_idle_busy", 32'(bsy), 0);

    // Rejection: size 0 then negative size
    set_ch(2, 32'hC200, 32'hD200, 32'd0, 1'b0);
    set_ch(3, 32'hC300, 32'hD300, 32'h8000_0000, 1'b0);
    req = 4'b0100;
    tick();
    chk("rej2_err", 32'(err), 32'h4);
    chk("rej2_valid", 32'(c_valid), 0);
    chk("rej2_busy", 32'(bsy), 1);
    req = 4'b0000;
    tick();
    chk("rej2_err_1cyc", 32'(err), 0);
    chk("rej2_idle", 32'(bsy), 0);
    chk("rej2_valid2", 32'(c_valid), 0);
    req = 4'b1000;
    tick();
    chk("rej3_err", 32'(err), 32'h8);
    chk("rej3_valid", 32'(c_valid), 0);
    chk("rej3_size_cap", c_size, 32'h8000_0000);
    req = 4'b0000;
    tick();
    chk("rej3_idle", 32'(bsy), 0);
    chk("rej3_valid2", 32'(c_valid), 0);

    // Spurious done while idle
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("spur_ack", 32'(ack), 0);
    chk("spur_busy", 32'(bsy), 0);
    tick();
    chk("spur_ack2", 32'(ack), 0);

    // Reset while waiting
    req = 4'b0001;
    tick();
    chk("midrst_valid", 32'(c_valid), 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b0000;
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_busy", 32'(bsy), 0);
    chk("midrst_valid0", 32'(c_valid), 0);
    chk("midrst_size", c_size, 0);
    chk("midrst_host", c_host, 0);
    chk("midrst_active", 32'(act), 0);
    tick();
    chk("midrst_ack_after", 32'(ack), 0);

    // Timeout on the 16-cycle instance
    set_ch(2, 32'hE200, 32'hF200, 32'h100, 1'b0);
    req_b = 4'b0100;
    tick();
    chk("to_valid", 32'(c_valid_b), 1);
    tick();
    chk("to_w_err", 32'(err_b), 0);
    for (int i = 0; i < 15; i++) tick();
    chk("to_w15_err", 32'(err_b), 0);
    chk("to_w15_fault", 32'(flt_b), 0);
    tick();
    chk("to_err", 32'(err_b), 32'h4);
    chk("to_fault", 32'(flt_b), 1);
    chk("to_busy", 32'(bsy_b), 1);
    req_b = 4'b0001;
    tick();
    chk("to_err_1cyc", 32'(err_b), 0);
    chk("to_fault_sticky", 32'(flt_b), 1);
    tick(); tick();
    chk("to_no_grant", 32'(c_valid_b), 0);
    chk("to_fault_sticky2", 32'(flt_b), 1);
    rst_b = 1'b1; req_b = 4'b0011;
    tick();
    rst_b = 1'b0;
    chk("to_rst_fault", 32'(flt_b), 0);
    chk("to_rst_busy", 32'(bsy_b), 0);
    tick();
    chk("to_rst_valid", 32'(c_valid_b), 1);
    chk("to_rst_first_ch0", 32'(act_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
